// File: rtl/pulse_cfg_pkg.sv
// Shared constants and types for the pulse
// parameter loader and the pulses top level.
package pulse_cfg_pkg;

  localparam logic [7:0] A_PERIOD    = 8'h01;
  localparam logic [7:0] A_P1WIDTH   = 8'h02;
  localparam logic [7:0] A_DELAY     = 8'h03;
  localparam logic [7:0] A_P2WIDTH   = 8'h04;
  localparam logic [7:0] A_PUMP      = 8'h05;
  localparam logic [7:0] A_BLOCK     = 8'h06;
  localparam logic [7:0] A_PBLOCK    = 8'h07;
  localparam logic [7:0] A_PBLOCK_OFF = 8'h08;
  localparam logic [7:0] A_CPMG      = 8'h09;
  localparam logic [7:0] A_PRE_ATT   = 8'h0A;
  localparam logic [7:0] A_POST_ATT  = 8'h0B;
  localparam logic [7:0] C_APPLY     = 8'h10;
  localparam logic [7:0] C_REVERT    = 8'h11;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  localparam logic [31:0] ST_PERIOD     = 32'd201000;
  localparam logic [31:0] ST_P1WIDTH    = 32'd30;
  localparam logic [31:0] ST_DELAY      = 32'd200;
  localparam logic [31:0] ST_P2WIDTH    = 32'd60;
  localparam logic        ST_PUMP       = 1'b1;
  localparam logic        ST_BLOCK      = 1'b1;
  localparam logic [7:0]  ST_PBLOCK     = 8'd50;
  localparam logic [15:0] ST_PBLOCK_OFF = 16'd100;
  localparam logic [7:0]  ST_CPMG       = 8'd5;
  localparam logic [6:0]  ST_PRE_ATT    = 7'h00;
  localparam logic [6:0]  ST_POST_ATT   = 7'h7F;

  typedef enum logic {
    S_IDLE,
    S_DATA
  } fa_state_e;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] p1width;
    logic [31:0] delay;
    logic [31:0] p2width;
    logic        pump;
    logic        block;
    logic [7:0]  pulse_block;
    logic [15:0] pulse_block_off;
    logic [7:0]  cpmg;
    logic [6:0]  pre_att;
    logic [6:0]  post_att;
  } cfg_t;

  localparam cfg_t CFG_DEFAULT = '{
    period:          ST_PERIOD,
    p1width:         ST_P1WIDTH,
    delay:           ST_DELAY,
    p2width:         ST_P2WIDTH,
    pump:            ST_PUMP,
    block:           ST_BLOCK,
    pulse_block:     ST_PBLOCK,
    pulse_block_off: ST_PBLOCK_OFF,
    cpmg:            ST_CPMG,
    pre_att:         ST_PRE_ATT,
    post_att:        ST_POST_ATT
  };

  // Data byte count of a field address; 0 means
  // the code is not a field.
  function automatic logic [2:0] field_len(
    input logic [7:0] a
  );
    logic [2:0] n;
    n = 3'd0;
    case (a)
      A_PERIOD, A_P1WIDTH,
      A_DELAY, A_P2WIDTH:   n = 3'd4;
      A_PBLOCK_OFF:         n = 3'd2;
      A_PUMP, A_BLOCK,
      A_PBLOCK, A_CPMG,
      A_PRE_ATT, A_POST_ATT: n = 3'd1;
      default:              n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pulse_param_loader_frame_assembler.sv
// Command framer: decodes codes, gathers little-endian
// data bytes and aborts stalled frames.
module frame_assembler
  import pulse_cfg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk_pll,
  input  logic        resetn,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        wr_stb,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_value,
  output logic        apply_stb,
  output logic        revert_stb,
  output logic        err_stb
);

  localparam logic [31:0] TMO_LAST =
    32'(TIMEOUT_CYCLES - 1);

  fa_state_e   state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [1:0]  lm1_q, lm1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] tmo_q, tmo_d;
  logic [2:0]  len;
  logic [1:0]  pos;

  // Frame state, byte position and idle-gap counter.
  always_ff @(posedge clk_pll) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      lm1_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lm1_q   <= lm1_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      tmo_q   <= tmo_d;
    end
  end

  // Decode, assemble, and emit strobes the same cycle.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    lm1_d      = lm1_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    wr_stb     = 1'b0;
    apply_stb  = 1'b0;
    revert_stb = 1'b0;
    err_stb    = 1'b0;
    wr_addr    = addr_q;
    wr_value   = asm_q;
    len        = field_len(rx_byte);
    pos        = lm1_q - cnt_q;

    if (rx_valid)
      tmo_d = '0;
    else if (state_q == S_DATA)
      tmo_d = tmo_q + 32'd1;
    else
      tmo_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          unique case (1'b1)
            (len != 3'd0): begin
              addr_d  = rx_byte;
              lm1_d   = 2'(len - 3'd1);
              cnt_d   = 2'(len - 3'd1);
              asm_d   = '0;
              state_d = S_DATA;
            end
            (rx_byte == C_APPLY):  apply_stb  = 1'b1;
            (rx_byte == C_REVERT): revert_stb = 1'b1;
            default:               err_stb    = 1'b1;
          endcase
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          asm_d[{pos, 3'b000} +: 8] = rx_byte;
          if (cnt_q == 2'd0) begin
            wr_stb   = 1'b1;
            wr_value = asm_d;
            state_d  = S_IDLE;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_stb = 1'b1;
          state_d = S_IDLE;
          tmo_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: rtl/pulse_param_loader.sv
// Shadow/live pulse parameter bank with period-aligned
// commit and an ACK/NAK response register.
module pulse_param_loader
  import pulse_cfg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk_pll,
  input  logic        resetn,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        period_start,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] period,
  output logic [31:0] p1width,
  output logic [31:0] delay,
  output logic [31:0] p2width,
  output logic        pump,
  output logic        block,
  output logic [7:0]  pulse_block,
  output logic [15:0] pulse_block_off,
  output logic [7:0]  cpmg,
  output logic [6:0]  pre_att,
  output logic [6:0]  post_att,
  output logic        pending,
  output logic        update_done,
  output logic        overrun
);

  logic        wr_stb;
  logic [7:0]  wr_addr;
  logic [31:0] wr_value;
  logic        apply_stb;
  logic        revert_stb;
  logic        err_stb;

  cfg_t        shadow_q, shadow_d;
  cfg_t        live_q, live_d;
  logic        pending_q, pending_d;
  logic        upd_q, upd_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        overrun_q, overrun_d;
  logic        commit;
  logic        resp_vld;
  logic [7:0]  resp_byte;

  frame_assembler #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fa (
    .clk_pll    (clk_pll),
    .resetn     (resetn),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .wr_stb     (wr_stb),
    .wr_addr    (wr_addr),
    .wr_value   (wr_value),
    .apply_stb  (apply_stb),
    .revert_stb (revert_stb),
    .err_stb    (err_stb)
  );

  // Register bank, commit flags and response register.
  always_ff @(posedge clk_pll) begin
    if (!resetn) begin
      shadow_q   <= CFG_DEFAULT;
      live_q     <= CFG_DEFAULT;
      pending_q  <= 1'b0;
      upd_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      overrun_q  <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      live_q     <= live_d;
      pending_q  <= pending_d;
      upd_q      <= upd_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
      overrun_q  <= overrun_d;
    end
  end

  // Commit uses pre-write shadow; commands that cycle
  // defer it to the next strobe.
  always_comb begin
    shadow_d   = shadow_q;
    live_d     = live_q;
    pending_d  = pending_q;
    upd_d      = 1'b0;
    tx_valid_d = tx_valid_q;
    tx_byte_d  = tx_byte_q;
    overrun_d  = overrun_q;
    resp_vld   = 1'b0;
    resp_byte  = ACK;
    commit     = period_start && pending_q &&
                 !apply_stb && !revert_stb;

    if (commit) begin
      live_d    = shadow_q;
      pending_d = 1'b0;
      upd_d     = 1'b1;
    end

    if (wr_stb) begin
      resp_vld = 1'b1;
      unique case (wr_addr)
        A_PERIOD:  shadow_d.period  = wr_value;
        A_P1WIDTH: shadow_d.p1width = wr_value;
        A_DELAY:   shadow_d.delay   = wr_value;
        A_P2WIDTH: shadow_d.p2width = wr_value;
        A_PUMP:    shadow_d.pump    = wr_value[0];
        A_BLOCK:   shadow_d.block   = wr_value[0];
        A_PBLOCK:
          shadow_d.pulse_block = wr_value[7:0];
        A_PBLOCK_OFF:
          shadow_d.pulse_block_off = wr_value[15:0];
        A_CPMG:    shadow_d.cpmg    = wr_value[7:0];
        A_PRE_ATT:
          shadow_d.pre_att = wr_value[6:0];
        A_POST_ATT:
          shadow_d.post_att = wr_value[6:0];
        default: ;
      endcase
    end

    if (apply_stb) begin
      resp_vld = 1'b1;
      if (shadow_q.period == 32'd0)
        resp_byte = NAK;
      else
        pending_d = 1'b1;
    end

    if (revert_stb) begin
      resp_vld  = 1'b1;
      shadow_d  = live_q;
      pending_d = 1'b0;
    end

    if (err_stb) begin
      resp_vld  = 1'b1;
      resp_byte = NAK;
    end

    if (tx_valid_q && tx_ready)
      tx_valid_d = 1'b0;

    if (resp_vld) begin
      if (!tx_valid_q || tx_ready) begin
        tx_byte_d  = resp_byte;
        tx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign tx_byte         = tx_byte_q;
  assign tx_valid        = tx_valid_q;
  assign period          = live_q.period;
  assign p1width         = live_q.p1width;
  assign delay           = live_q.delay;
  assign p2width         = live_q.p2width;
  assign pump            = live_q.pump;
  assign block           = live_q.block;
  assign pulse_block     = live_q.pulse_block;
  assign pulse_block_off = live_q.pulse_block_off;
  assign cpmg            = live_q.cpmg;
  assign pre_att         = live_q.pre_att;
  assign post_att        = live_q.post_att;
  assign pending         = pending_q;
  assign update_done     = upd_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_pulse_param_loader.sv
// Scoreboard bench for pulse_param_loader with a
// field-table reference model.
module tb_pulse_param_loader;

  localparam int TO = 64;

  logic        clk_pll;
  logic        resetn;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        period_start;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] period, p1width, delay, p2width;
  logic        pump, block;
  logic [7:0]  pulse_block;
  logic [15:0] pulse_block_off;
  logic [7:0]  cpmg;
  logic [6:0]  pre_att, post_att;
  logic        pending, update_done, overrun;

  pulse_param_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_pll(clk_pll), .resetn(resetn),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .period_start(period_start),
    .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .period(period), .p1width(p1width),
    .delay(delay), .p2width(p2width),
    .pump(pump), .block(block),
    .pulse_block(pulse_block),
    .pulse_block_off(pulse_block_off),
    .cpmg(cpmg), .pre_att(pre_att),
    .post_att(post_att), .pending(pending),
    .update_done(update_done), .overrun(overrun)
  );

  initial clk_pll = 1'b0;
  always #5 clk_pll = ~clk_pll;

  // reference model: fields indexed by address code
  logic [31:0] m_sh[16];
  logic [31:0] m_lv[16];
  bit          m_pend, m_upd, m_full, m_ovr;
  bit          m_inframe;
  int          m_idle;
  logic [7:0]  m_addr;
  logic [7:0]  m_bytes[$];
  logic [7:0]  exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          mon_en = 0;
  bit          stall_prev = 0;
  logic [7:0]  held = 8'h00;

  function automatic int flen(input logic [7:0] a);
    case (a)
      8'h01, 8'h02, 8'h03, 8'h04: return 4;
      8'h08: return 2;
      8'h05, 8'h06, 8'h07, 8'h09,
      8'h0A, 8'h0B: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] fmask(input logic [7:0] a);
    case (a)
      8'h01, 8'h02, 8'h03, 8'h04: return 32'hFFFF_FFFF;
      8'h05, 8'h06: return 32'h1;
      8'h07, 8'h09: return 32'hFF;
      8'h08: return 32'hFFFF;
      8'h0A, 8'h0B: return 32'h7F;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_sh[i] = 32'd0;
    m_sh[1] = 32'd201000; m_sh[2] = 32'd30;
    m_sh[3] = 32'd200;    m_sh[4] = 32'd60;
    m_sh[5] = 32'd1;      m_sh[6] = 32'd1;
    m_sh[7] = 32'd50;     m_sh[8] = 32'd100;
    m_sh[9] = 32'd5;      m_sh[10] = 32'h00;
    m_sh[11] = 32'h7F;
    m_lv = m_sh;
    m_pend = 0; m_upd = 0; m_full = 0; m_ovr = 0;
    m_inframe = 0; m_idle = 0;
    m_bytes.delete();
    exp_q.delete();
  endtask

  // one clock edge of the spec's rules
  task automatic model_step(input bit rv,
                            input logic [7:0] b,
                            input bit ps,
                            input bit rdy);
    int resp;
    bit cmd;
    logic [31:0] v;
    logic [31:0] sh_old[16];
    logic [31:0] lv_old[16];
    if (!resetn) begin
      m_reset();
      return;
    end
    resp = -1; cmd = 0;
    sh_old = m_sh; lv_old = m_lv;
    m_upd = 0;
    if (rv) begin
      m_idle = 0;
      if (m_inframe) begin
        m_bytes.push_back(b);
        if (m_bytes.size() == flen(m_addr)) begin
          v = 32'd0;
          foreach (m_bytes[i])
            v = v | (32'(m_bytes[i]) << (8 * i));
          m_sh[m_addr[3:0]] = v & fmask(m_addr);
          resp = 32'h06;
          m_inframe = 0;
        end
      end else if (flen(b) > 0) begin
        m_inframe = 1; m_addr = b; m_bytes.delete();
      end else if (b == 8'h10) begin
        cmd = 1;
        resp = (sh_old[1] == 0) ? 32'h15 : 32'h06;
      end else if (b == 8'h11) begin
        cmd = 1; m_sh = lv_old; resp = 32'h06;
      end else begin
        resp = 32'h15;
      end
    end else if (m_inframe) begin
      m_idle++;
      if (m_idle == TO) begin
        m_inframe = 0; resp = 32'h15;
      end
    end
    if (ps && m_pend && !cmd) begin
      m_lv = sh_old; m_pend = 0; m_upd = 1;
    end
    if (cmd && b == 8'h10 && sh_old[1] != 0) m_pend = 1;
    if (cmd && b == 8'h11) m_pend = 0;
    if (resp >= 0) begin
      if (!m_full || rdy) begin
        exp_q.push_back(8'(resp)); m_full = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_full && rdy) begin
      m_full = 0;
    end
  endtask

  task automatic tick(input bit rv,
                      input logic [7:0] b,
                      input bit ps);
    rx_valid = rv; rx_byte = b; period_start = ps;
    @(posedge clk_pll);
    model_step(rv, b, ps, tx_ready);
    #1;
    rx_valid = 1'b0; period_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    tick(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  function automatic bit rps();
    return ($urandom_range(0, 5) == 0);
  endfunction

  // monitor: scoreboard pops on each handshake
  always @(negedge clk_pll) begin
    if (mon_en) begin
      check("tx_valid", 32'(tx_valid), 32'(m_full));
      check("pending", 32'(pending), 32'(m_pend));
      check("update_done", 32'(update_done), 32'(m_upd));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("period", period, m_lv[1]);
      check("p1width", p1width, m_lv[2]);
      check("delay", delay, m_lv[3]);
      check("p2width", p2width, m_lv[4]);
      check("pump", 32'(pump), m_lv[5]);
      check("block", 32'(block), m_lv[6]);
      check("pulse_block", 32'(pulse_block), m_lv[7]);
      check("pulse_block_off", 32'(pulse_block_off),
            m_lv[8]);
      check("cpmg", 32'(cpmg), m_lv[9]);
      check("pre_att", 32'(pre_att), m_lv[10]);
      check("post_att", 32'(post_att), m_lv[11]);
      if (stall_prev && tx_valid)
        check("tx_hold", 32'(tx_byte), 32'(held));
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL tx_unexpected: got %02h expected none",
                   tx_byte);
        end else begin
          check("tx_byte", 32'(tx_byte),
                32'(exp_q.pop_front()));
        end
      end
      stall_prev = tx_valid && !tx_ready;
      held = tx_byte;
    end
  end

  initial begin
    int r, n;
    logic [7:0] code;
    resetn = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    period_start = 1'b0; tx_ready = 1'b1;
    tick(1'b0, 8'h00, 1'b0);
    mon_en = 1;
    idle(2);
    resetn = 1'b1;
    check("rst_period", period, 32'd201000);
    check("rst_p1width", p1width, 32'd30);
    check("rst_post_att", 32'(post_att), 32'h7F);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    idle(2);

    // field write then apply
    send(8'h01); send(8'h40); send(8'h0D);
    send(8'h03); send(8'h00); send(8'h10);
    idle(3);
    check("wr_pending", 32'(pending), 32'd1);
    check("wr_period_old", period, 32'd201000);
    tick(1'b0, 8'h00, 1'b1);
    check("commit_period", period, 32'd200000);
    check("commit_upd", 32'(update_done), 32'd1);
    idle(1);
    check("commit_upd_off", 32'(update_done), 32'd0);

    // timeout mid-frame
    send(8'h02); send(8'h1E);
    idle(TO + 2);
    send(8'h10); idle(1);
    tick(1'b0, 8'h00, 1'b1); idle(1);
    check("tmo_p1width", p1width, 32'd30);
    check("tmo_drained", 32'(exp_q.size()), 32'd0);

    // bad code, zero period, rejected apply
    send(8'h7E);
    send(8'h01); send(8'h00); send(8'h00);
    send(8'h00); send(8'h00); send(8'h10);
    idle(3);
    check("err_pending", 32'(pending), 32'd0);

    // write landing on the commit edge
    send(8'h01); send(8'hA0); send(8'h86);
    send(8'h01); send(8'h00);
    send(8'h05); send(8'h00); send(8'h10);
    idle(2);
    send(8'h05); tick(1'b1, 8'h01, 1'b1);
    idle(1);
    check("coll_pump", 32'(pump), 32'd0);
    check("coll_period", period, 32'd100000);
    send(8'h11); idle(1);
    send(8'h10); idle(1);
    tick(1'b0, 8'h00, 1'b1); idle(1);
    check("revert_pump", 32'(pump), 32'd0);

    // backpressure
    tx_ready = 1'b0;
    idle(1);
    send(8'h7E); idle(1);
    send(8'h7E); idle(1);
    send(8'h7E); idle(1);
    check("bp_overrun", 32'(overrun), 32'd1);
    check("bp_tx_valid", 32'(tx_valid), 32'd1);
    check("bp_tx_byte", 32'(tx_byte), 32'h15);
    tx_ready = 1'b1;
    idle(2);
    check("bp_tx_done", 32'(tx_valid), 32'd0);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a frame
    send(8'h01); send(8'hAA);
    resetn = 1'b0;
    idle(1);
    resetn = 1'b1;
    check("rst2_overrun", 32'(overrun), 32'd0);
    check("rst2_period", period, 32'd201000);
    send(8'h00); idle(1);

    // random frames
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 15);
      if (r < 11) code = 8'(r + 1);
      else if (r == 11 || r == 15) code = 8'h10;
      else if (r == 12) code = 8'h11;
      else if (r == 13) code = 8'($urandom_range(8'h12, 8'hFF));
      else code = 8'h00;
      tick(1'b1, code, rps());
      n = flen(code);
      if (n > 0 && $urandom_range(0, 29) == 0) begin
        tick(1'b1, 8'($urandom), rps());
        idle(TO + 1);
      end else begin
        for (int j = 0; j < n; j++) begin
          for (int g = $urandom_range(0, 2); g > 0; g--)
            tick(1'b0, 8'h00, rps());
          tick(1'b1, 8'($urandom), rps());
        end
      end
      for (int g = $urandom_range(0, 2); g > 0; g--)
        tick(1'b0, 8'h00, rps());
    end
    idle(5);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_param_loader.md
Name: pulse_param_loader

Overview:
- Byte-stream command decoder that configures the pulse sequencer: period, p1width, delay, p2width, pump, block, pulse_block, pulse_block_off, cpmg, pre_att and post_att.
- Writes land in shadow registers. An APPLY command arms a commit, and the live outputs update atomically on the next period-start strobe, so a sequence is never changed mid-period.
- Sits between the UART receiver (already synchronised into clk_pll) and the pulses block. It returns ACK/NAK bytes to the UART transmitter.

Parameters:
- TIMEOUT_CYCLES, 2000000: maximum idle gap between bytes of one frame before the frame is aborted.
- ST_PERIOD, 201000: reset value of period.
- ST_P1WIDTH, 30: reset value of p1width.
- ST_DELAY, 200: reset value of delay.
- ST_P2WIDTH, 60: reset value of p2width.
- ST_PUMP, 1; ST_BLOCK, 1; ST_PBLOCK, 50; ST_PBLOCK_OFF, 100; ST_CPMG, 5: reset values of the matching fields.
- ST_PRE_ATT, 7'h00; ST_POST_ATT, 7'h7F: reset values of the attenuator words.

Ports:
- clk_pll  in  1  sole clock
- resetn  in  1  synchronous, active-low reset
- rx_byte  in  8  received byte
- rx_valid  in  1  one-cycle strobe qualifying rx_byte
- period_start  in  1  one-cycle strobe from pulses at each period boundary
- tx_byte  out  8  response byte
- tx_valid  out  1  response valid; held until tx_ready
- tx_ready  in  1  transmitter accepts tx_byte when tx_valid && tx_ready
- period, p1width, delay, p2width  out  32 each  live values
- pump, block  out  1 each  live values
- pulse_block  out  8  live value
- pulse_block_off  out  16  live value
- cpmg  out  8  live value
- pre_att, post_att  out  7 each  live values
- pending  out  1  APPLY armed, commit not yet done
- update_done  out  1  one-cycle strobe on the cycle the live registers load
- overrun  out  1  sticky: a response was dropped because tx was busy

Behaviour:
- Reset (resetn=0 at a clk_pll edge):
  - Shadow and live registers load the ST_* values.
  - pending, update_done, tx_valid and overrun go to 0; tx_byte goes to 0x00.
  - FSM goes to IDLE and the timeout counter goes to 0.
  - A reset mid-frame discards the partial frame.
- Address map (command byte, number of data bytes, little-endian):
  - 0x01 period, 4 bytes
  - 0x02 p1width, 4
  - 0x03 delay, 4
  - 0x04 p2width, 4
  - 0x05 pump, 1 (bit0)
  - 0x06 block, 1 (bit0)
  - 0x07 pulse_block, 1
  - 0x08 pulse_block_off, 2
  - 0x09 cpmg, 1
  - 0x0A pre_att, 1 (bits 6:0)
  - 0x0B post_att, 1 (bits 6:0)
  - 0x10 APPLY, 0 bytes
  - 0x11 REVERT, 0 bytes: copy live into shadow and clear pending
- FSM:
  - IDLE: on rx_valid, decode the byte.
    - Field address: latch it, set byte_cnt = length-1, go to DATA.
    - APPLY or REVERT: execute, queue ACK (0x06), stay in IDLE.
    - Unknown code: queue NAK (0x15).
  - DATA: each rx_valid shifts the byte into an assembly register at position (length-1-byte_cnt).
    - Last byte: write the assembled value to the shadow field (unused upper bits ignored), queue ACK, return to IDLE.
  - Timeout: the counter clears on every rx_valid and increments in DATA. At TIMEOUT_CYCLES-1 the FSM aborts to IDLE, queues NAK and leaves the shadow untouched.
- APPLY:
  - If shadow period == 0: NAK, pending unchanged.
  - Otherwise: pending=1 and ACK. Repeated APPLY while pending stays pending and ACKs.
- Commit:
  - On a cycle with period_start && pending, all live registers load from shadow at the next edge.
  - On that same edge pending clears and update_done pulses for 1 cycle.
  - Latency from strobe to outputs: 1 cycle.
- Simultaneous events:
  - Shadow write and commit in the same cycle: live takes the pre-write shadow value; the new shadow value is kept for a later APPLY.
  - APPLY and period_start in the same cycle: the commit happens at the next period_start, not this one.
  - REVERT and period_start in the same cycle: REVERT wins and no commit happens.
- Response path:
  - A queued response loads tx_byte and sets tx_valid when tx_valid==0.
  - It also loads when tx_valid && tx_ready, i.e. the outgoing byte is accepted that cycle.
  - Otherwise the new response is dropped and overrun=1 (cleared only by reset).
  - tx_byte is stable while tx_valid=1.

Decomposition:
- Package pulse_cfg_pkg holds:
  - address codes and field lengths
  - ACK/NAK constants
  - FSM state enum
  - ST_* default values, shared with the pulses top level
- Sub-module: frame_assembler, holding the FSM, byte counter, timeout counter and little-endian assembly register. It outputs a (addr, value, write strobe) tuple plus cmd strobes.
- The shadow/live register bank and the response queue stay in the top module.

Test Plan:
- Reset: release resetn; live period=201000, p1width=30, post_att=0x7F, tx_valid=0, pending=0.
- Field write and commit: send 01 40 0D 03 00 then 10; two ACKs (0x06), pending=1, live period still 201000. Pulse period_start; the next cycle shows period=200000 and update_done=1 for exactly one cycle.
- Timeout: send 02 1E, then idle TIMEOUT_CYCLES; NAK (0x15) and shadow p1width unchanged. A subsequent 10 plus period_start leaves p1width=30.
- Errors: send 0x7E, then 01 00 00 00 00 10; NAK for the bad code, ACK for the write, NAK for the APPLY with pending=0.
- Collision: 05 00 then 10, then send 05 01 so its last byte lands on the period_start cycle; after commit pump=0 and shadow pump=1. REVERT (11) restores shadow pump=0.
- Backpressure: hold tx_ready=0 and send three commands; the first response is held and the next two are dropped, overrun=1, tx_byte stable. Raise tx_ready; one byte transfers.
